// File: rtl/atan2_angle_quantiser.sv
// Three-stage angle quantiser for ORB orientation: compares |y|<<FRAC_BITS against |x|*T[k]
// for every tangent threshold and reports quadrant, in-quadrant bin and global angle index.
module atan2_angle_quantiser #(
  parameter int BIT_WIDTH = 12,
  parameter int FRAC_BITS = 9,
  parameter int NUM_T     = 25,
  parameter int T_WIDTH   = 12,
  parameter logic [NUM_T*T_WIDTH-1:0] TAN_TABLE = {
    12'd2036, 12'd676, 12'd404, 12'd286, 12'd220, 12'd177, 12'd147, 12'd125, 12'd108,
    12'd94, 12'd82, 12'd72, 12'd63, 12'd56, 12'd49, 12'd43, 12'd37, 12'd32, 12'd27,
    12'd23, 12'd18, 12'd14, 12'd10, 12'd6, 12'd2},
  parameter int IDX_W     = $clog2(4*(NUM_T+1)),
  localparam int BIN_W    = $clog2(NUM_T+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 in_valid,
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [BIT_WIDTH-1:0] y,
  output logic                 out_valid,
  output logic [1:0]           quadrant,
  output logic [BIN_W-1:0]     bin,
  output logic [IDX_W-1:0]     angle_idx
);

  localparam int PW = BIT_WIDTH + T_WIDTH;
  localparam int YW = BIT_WIDTH + FRAC_BITS;
  localparam int CW = (PW > YW) ? PW : YW;

  // Constant multiply as a sum of shifted copies; c is a table constant so this folds to adders.
  function automatic logic [PW-1:0] mul_const(input logic [BIT_WIDTH-1:0] a,
                                              input logic [T_WIDTH-1:0] c);
    logic [PW-1:0] acc;
    acc = '0;
    for (int b = 0; b < T_WIDTH; b++) begin
      if (c[b]) acc = acc + (PW'(a) << b);
    end
    return acc;
  endfunction

  // Stage 1 state
  logic                 s1_valid_reg;
  logic [1:0]           s1_quad_reg;
  logic [BIT_WIDTH-1:0] ax_reg, ay_reg;
  // Stage 2 state
  logic                 s2_valid_reg;
  logic [1:0]           s2_quad_reg;
  logic [PW-1:0]        p_reg [NUM_T];
  logic [YW-1:0]        y_reg;

  logic [BIT_WIDTH-1:0] ax_next, ay_next;
  logic [1:0]           quad_next;
  logic [PW-1:0]        p_next [NUM_T];
  logic [YW-1:0]        y_next;
  logic [NUM_T-1:0]     ge;
  logic [BIN_W-1:0]     cnt;
  logic [BIN_W-1:0]     bin_next;
  logic [IDX_W-1:0]     idx_next;

  // Two's complement negation of the most negative value wraps to 2^(BIT_WIDTH-1), which is
  // exactly its magnitude when read as unsigned.
  assign ax_next   = x[BIT_WIDTH-1] ? (~x + BIT_WIDTH'(1)) : x;
  assign ay_next   = y[BIT_WIDTH-1] ? (~y + BIT_WIDTH'(1)) : y;
  assign quad_next = {y[BIT_WIDTH-1], x[BIT_WIDTH-1] ^ y[BIT_WIDTH-1]};
  assign y_next    = YW'(ay_reg) << FRAC_BITS;

  for (genvar gi = 0; gi < NUM_T; gi++) begin : g_thresh
    localparam logic [T_WIDTH-1:0] TK = TAN_TABLE[gi*T_WIDTH +: T_WIDTH];
    assign p_next[gi] = mul_const(ax_reg, TK);
    assign ge[gi]     = CW'(y_reg) >= CW'(p_reg[gi]);
  end

  // Thresholds are monotonic, so ge is a thermometer code and its popcount is the bin.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < NUM_T; k++) begin
      cnt = cnt + BIN_W'(ge[k]);
    end
  end

  // Odd quadrants run the angle the other way relative to |y|/|x|.
  assign bin_next = s2_quad_reg[0] ? (BIN_W'(NUM_T) - cnt) : cnt;
  assign idx_next = IDX_W'(s2_quad_reg) * IDX_W'(NUM_T + 1) + IDX_W'(bin_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_quad_reg  <= '0;
      ax_reg       <= '0;
      ay_reg       <= '0;
      s2_valid_reg <= 1'b0;
      s2_quad_reg  <= '0;
      y_reg        <= '0;
      for (int k = 0; k < NUM_T; k++) p_reg[k] <= '0;
      out_valid    <= 1'b0;
      quadrant     <= '0;
      bin          <= '0;
      angle_idx    <= '0;
    end else if (ena) begin
      s1_valid_reg <= in_valid;
      s1_quad_reg  <= quad_next;
      ax_reg       <= ax_next;
      ay_reg       <= ay_next;
      s2_valid_reg <= s1_valid_reg;
      s2_quad_reg  <= s1_quad_reg;
      y_reg        <= y_next;
      for (int k = 0; k < NUM_T; k++) p_reg[k] <= p_next[k];
      out_valid    <= s2_valid_reg;
      quadrant     <= s2_quad_reg;
      bin          <= bin_next;
      angle_idx    <= idx_next;
    end
  end

endmodule

// File: tb/tb_atan2_angle_quantiser.sv
// Scoreboard bench for atan2_angle_quantiser: stimulus pushes model results, a monitor pops
// them as the DUT presents outputs and also checks reset clearing and ena=0 hold.
module tb_atan2_angle_quantiser;

  localparam int BW    = 12;
  localparam int NT    = 25;
  localparam int FRAC  = 9;
  localparam int BIN_W = 5;
  localparam int IDX_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b0;
  logic             in_valid = 1'b0;
  logic [BW-1:0]    x = '0;
  logic [BW-1:0]    y = '0;
  logic             out_valid;
  logic [1:0]       quadrant;
  logic [BIN_W-1:0] bin;
  logic [IDX_W-1:0] angle_idx;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int quad;
    int bin;
    int idx;
    int due;
  } exp_t;
  exp_t sbq[$];

  // Tangent thresholds in ascending order, entry k compared as |y|*2^FRAC >= |x|*T[k].
  int tan_t[NT] = '{2, 6, 10, 14, 18, 23, 27, 32, 37, 43, 49, 56, 63, 72, 82, 94,
                    108, 125, 147, 177, 220, 286, 404, 676, 2036};

  int scnt = 0;  // ena-advance edges seen by stimulus
  int mcnt = 0;  // ena-advance edges seen by monitor

  atan2_angle_quantiser dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(out_valid), .quadrant(quadrant), .bin(bin), .angle_idx(angle_idx)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int xi, input int yi, input int due);
    exp_t e;
    longint ax, ay;
    int q, c;
    ax = (xi < 0) ? -xi : xi;
    ay = (yi < 0) ? -yi : yi;
    if (yi >= 0) q = (xi >= 0) ? 0 : 1;
    else         q = (xi < 0) ? 2 : 3;
    c = 0;
    for (int k = 0; k < NT; k++) if (ay * (2 ** FRAC) >= ax * tan_t[k]) c++;
    e.quad = q;
    e.bin  = (q == 0 || q == 2) ? c : NT - c;
    e.idx  = q * (NT + 1) + e.bin;
    e.due  = due;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, bookkeeping at the rising edge.
  task automatic drive(input logic v, input int xi, input int yi, input logic e, input logic r);
    @(negedge clk);
    in_valid = v;
    x = BW'(xi);
    y = BW'(yi);
    ena = e;
    rst = r;
    @(posedge clk);
    if (r) begin
      sbq.delete();
    end else if (e) begin
      scnt++;
      if (v) begin
        sbq.push_back(model(xi, yi, scnt + 2));
        $display("IN  x=%0d y=%0d due=%0d", xi, yi, scnt + 2);
      end
    end
  endtask

  // Monitor
  initial begin
    logic e_s, r_s;
    logic pv;
    int pq, pb, pi;
    exp_t ex;
    pv = 0; pq = 0; pb = 0; pi = 0;
    forever begin
      @(posedge clk);
      e_s = ena;
      r_s = rst;
      if (e_s && !r_s) mcnt++;
      #1;
      if (r_s) begin
        check("reset_valid", int'(out_valid), 0);
        check("reset_quad", int'(quadrant), 0);
        check("reset_bin", int'(bin), 0);
        check("reset_idx", int'(angle_idx), 0);
      end else if (!e_s) begin
        check("hold_valid", int'(out_valid), int'(pv));
        check("hold_quad", int'(quadrant), pq);
        check("hold_bin", int'(bin), pb);
        check("hold_idx", int'(angle_idx), pi);
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          ex = sbq.pop_front();
          $display("OUT quad=%0d bin=%0d idx=%0d (exp %0d/%0d/%0d)",
                   quadrant, bin, angle_idx, ex.quad, ex.bin, ex.idx);
          check("latency", mcnt, ex.due);
          check("quadrant", int'(quadrant), ex.quad);
          check("bin", int'(bin), ex.bin);
          check("angle_idx", int'(angle_idx), ex.idx);
        end
      end else if (sbq.size() != 0 && sbq[0].due <= mcnt) begin
        check("missing_output", 0, 1);
        void'(sbq.pop_front());
      end
      pv = out_valid;
      pq = int'(quadrant);
      pb = int'(bin);
      pi = int'(angle_idx);
    end
  end

  // Stimulus
  initial begin
    int dx[10] = '{100, 1, -1, 256, -256, 256, -2048, 0, 0, 5};
    int dy[10] = '{0, 100, 100, 1, -1, -1, -2048, 0, 37, 0};
    int n;

    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);

    foreach (dx[i]) drive(1, dx[i], dy[i], 1, 0);
    repeat (4) drive(0, 0, 0, 1, 0);

    // Back-to-back valid samples while ena pulses 1,0,0.
    n = 0;
    for (int i = 0; n < 8; i++) begin
      drive(1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
            (i % 3) == 0, 0);
      if ((i % 3) == 0) n++;
    end
    repeat (4) drive(0, 0, 0, 1, 0);

    // Random traffic with bubbles and stalls, mixing wide and small magnitudes.
    for (int i = 0; i < 150; i++) begin
      int xr, yr;
      if ($urandom_range(0, 1) == 1) begin
        xr = int'($urandom_range(0, 4095)) - 2048;
        yr = int'($urandom_range(0, 4095)) - 2048;
      end else begin
        xr = int'($urandom_range(0, 600)) - 300;
        yr = int'($urandom_range(0, 60)) - 30;
      end
      drive(1'($urandom_range(0, 3) != 0), xr, yr, 1'($urandom_range(0, 4) != 0), 0);
    end
    repeat (4) drive(0, 0, 0, 1, 0);

    // Reset with three samples in flight; none of them may appear afterwards.
    drive(1, 300, 40, 1, 0);
    drive(1, -300, 40, 1, 0);
    drive(1, -300, -40, 1, 0);
    drive(1, 7, 7, 1, 1);
    repeat (5) drive(0, 0, 0, 1, 0);

    // Reset while stalled also clears.
    drive(1, 50, 20, 1, 0);
    drive(1, -50, 20, 1, 0);
    drive(1, 50, -20, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(1, 20, 50, 1, 0);

    // Bounded drain.
    for (int i = 0; i < 10 && sbq.size() != 0; i++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("drain_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
